cpu7_inst_resp: RTL and testbench

Instruction-fetch responder: the memory side of the `inst_*` fetch handshake driven by the IFU fetch datapath. Accepts up to two outstanding line-read requests, models a configurable memory latency with a per-request wait-state FSM, and reads 128-bit lines from a synchronous instruction SRAM. Returns responses in order with instruction count and fetch exceptions, and drops all outstanding work on `inst_cancel`. It sits between the IFU and the instruction RAM in simulation and FPGA builds.

---
 rtl/cpu7_inst_resp_if.sv | 38 +++
 rtl/cpu7_inst_resp.sv | 196 +++++++++++++++++++
 tb/tb_cpu7_inst_resp.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu7_inst_resp_if.sv
// ---------------------------------------------------------------------------
// cpu7_inst_resp_if
//   Instruction-fetch handshake between the IFU fetch datapath (master) and
//   the instruction memory responder (slave).
//
//   inst_req / inst_addr / inst_addr_ok : request channel, accepted when
//                                         inst_req && inst_addr_ok
//   inst_cancel                         : flush every outstanding request
//   inst_valid                          : one-cycle pulse per response
//   inst_rdata / inst_count             : line data (addressed word in [31:0])
//                                         and valid instruction count - 1
//   inst_ex / inst_exccode              : fetch exception and its code
//   inst_uncache                        : cacheability of the response
// ---------------------------------------------------------------------------
interface cpu7_inst_resp_if;
    logic         inst_req;
    logic [31:0]  inst_addr;
    logic         inst_addr_ok;
    logic         inst_cancel;
    logic         inst_valid;
    logic [127:0] inst_rdata;
    logic [1:0]   inst_count;
    logic         inst_ex;
    logic [5:0]   inst_exccode;
    logic         inst_uncache;

    modport master (
        output inst_req, inst_addr, inst_cancel,
        input  inst_addr_ok, inst_valid, inst_rdata, inst_count,
               inst_ex, inst_exccode, inst_uncache
    );

    modport slave (
        input  inst_req, inst_addr, inst_cancel,
        output inst_addr_ok, inst_valid, inst_rdata, inst_count,
               inst_ex, inst_exccode, inst_uncache
    );
endinterface

// File: rtl/cpu7_inst_resp.sv
// ---------------------------------------------------------------------------
// cpu7_inst_resp
//   Memory side of the instruction-fetch handshake. Queues up to two line-read
//   requests, waits WAIT_CYCLES before each SRAM read, and returns responses
//   in acceptance order. Misaligned or out-of-range fetches answer with ADEF
//   and never touch the SRAM. inst_cancel drops all outstanding work.
//
//   clock      : sole clock, rising edge
//   reset      : synchronous, active-high
//   inst       : fetch handshake (slave side of cpu7_inst_resp_if)
//   sram_en    : SRAM read enable
//   sram_addr  : SRAM line index
//   sram_rdata : SRAM line, valid the cycle after sram_en
// ---------------------------------------------------------------------------
module cpu7_inst_resp #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h1c000000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    cpu7_inst_resp_if.slave       inst,
    output logic                  sram_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [127:0]          sram_rdata
);

    localparam logic [63:0] MEM_BYTES  = 64'd16 << ADDR_WIDTH;
    localparam bit          HAS_WAIT   = (WAIT_CYCLES > 0);
    localparam logic [3:0]  WAIT_LOAD  = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [5:0]  EXC_ADEF   = 6'h08;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;

    // Two-entry request FIFO
    logic [31:0] fifo_addr [2];
    logic        fifo_ex   [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  fifo_cnt;

    logic        full, empty;
    logic        push, pop;
    logic        new_ex;
    logic        resp_fire;
    logic [31:0] head_addr;
    logic        head_ex;
    logic        serve_now;

    assign full      = (fifo_cnt == 2'd2);
    assign empty     = (fifo_cnt == 2'd0);
    assign head_addr = fifo_addr[rd_ptr];
    assign head_ex   = fifo_ex[rd_ptr];

    // Push is blocked while full even if the head pops this cycle, so
    // addr_ok depends only on registered state and the cancel input.
    assign inst.inst_addr_ok = !reset && !full && !inst.inst_cancel;
    assign push              = inst.inst_req && inst.inst_addr_ok;
    assign pop               = resp_fire;
    assign inst.inst_uncache = 1'b0;

    // Misaligned or outside the SRAM window. The unsigned subtraction wraps
    // addresses below the base to large offsets, so they fault as well.
    assign new_ex = (inst.inst_addr[1:0] != 2'b00) ||
                    ({32'b0, inst.inst_addr - BASE_ADDR} >= MEM_BYTES);

    // A good request arriving at an empty, idle responder starts its wait or
    // read in the acceptance cycle; a faulting one is answered from the FIFO
    // head one cycle later.
    assign serve_now = (!empty && !head_ex) || (empty && push && !new_ex);

    // ------------------------------------------------------------------
    // FSM next-state and control
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        sram_en   = 1'b0;
        resp_fire = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty && head_ex) begin
                    state_d = S_RESP;
                end else if (serve_now) begin
                    if (HAS_WAIT) begin
                        wait_d  = WAIT_LOAD;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = S_READ;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_READ: begin
                sram_en = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_fire = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Cancel (or reset) suppresses this cycle's read and response and
        // returns the FSM to IDLE; a read already in flight is simply ignored.
        if (reset || inst.inst_cancel) begin
            state_d   = S_IDLE;
            wait_d    = 4'd0;
            sram_en   = 1'b0;
            resp_fire = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset || inst.inst_cancel) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // NOTE: the entry storage has no reset; an entry is only read after a
    // push has written it, so only the pointers and count need clearing.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= inst.inst_addr;
            fifo_ex[wr_ptr]   <= new_ex;
        end
    end

    // ------------------------------------------------------------------
    // SRAM address and response data
    // ------------------------------------------------------------------
    assign sram_addr = sram_en ? ADDR_WIDTH'((head_addr - BASE_ADDR) >> 4)
                               : '0;

    always_comb begin
        inst.inst_valid   = resp_fire;
        inst.inst_rdata   = '0;
        inst.inst_count   = 2'd0;
        inst.inst_ex      = 1'b0;
        inst.inst_exccode = 6'd0;
        if (resp_fire) begin
            if (head_ex) begin
                inst.inst_ex      = 1'b1;
                inst.inst_exccode = EXC_ADEF;
            end else begin
                // Shift the addressed word down to [31:0]; words beyond the
                // end of the line fill with zero.
                inst.inst_rdata = sram_rdata >> {head_addr[3:2], 5'b0};
                inst.inst_count = 2'd3 - head_addr[3:2];
            end
        end
    end

endmodule

// File: tb/tb_cpu7_inst_resp.sv
// ---------------------------------------------------------------------------
// tb_cpu7_inst_resp
//   Two responders share one stimulus stream: dut0 with no wait states and
//   dut3 with three. Directed scenarios are followed by a randomized run that
//   is compared each cycle against a schedule-based reference model.
// ---------------------------------------------------------------------------
module tb_cpu7_inst_resp;

    localparam logic [31:0] BASE   = 32'h1c000000;
    localparam int          AW     = 10;
    localparam int          NLINES = 1 << AW;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        cancel;
    logic [31:0] addr;

    always #5 clock = ~clock;

    cpu7_inst_resp_if bus0 ();
    cpu7_inst_resp_if bus3 ();

    assign bus0.inst_req    = req;
    assign bus0.inst_addr   = addr;
    assign bus0.inst_cancel = cancel;
    assign bus3.inst_req    = req;
    assign bus3.inst_addr   = addr;
    assign bus3.inst_cancel = cancel;

    logic          sram_en0, sram_en3;
    logic [AW-1:0] sram_addr0, sram_addr3;
    logic [127:0]  sram_rdata0, sram_rdata3;

    cpu7_inst_resp #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
        .clock      (clock),
        .reset      (reset),
        .inst       (bus0),
        .sram_en    (sram_en0),
        .sram_addr  (sram_addr0),
        .sram_rdata (sram_rdata0)
    );

    cpu7_inst_resp #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut3 (
        .clock      (clock),
        .reset      (reset),
        .inst       (bus3),
        .sram_en    (sram_en3),
        .sram_addr  (sram_addr3),
        .sram_rdata (sram_rdata3)
    );

    // Instruction memory as 32-bit words; the SRAM models present it as lines.
    logic [31:0] words [NLINES*4];

    function automatic logic [127:0] line_of(input logic [AW-1:0] idx);
        int b;
        b = int'(idx) * 4;
        return {words[b+3], words[b+2], words[b+1], words[b]};
    endfunction

    always @(posedge clock) if (sram_en0) sram_rdata0 <= line_of(sram_addr0);
    always @(posedge clock) if (sram_en3) sram_rdata3 <= line_of(sram_addr3);

    int checks = 0;
    int errors = 0;

    // Reference: words from the addressed one to the end of the line.
    function automatic logic [127:0] exp_rdata(input logic [31:0] a);
        logic [31:0]  off;
        logic [127:0] res;
        int           line, o;
        off  = a - BASE;
        line = int'(off[AW+3:4]);
        o    = int'(a[3:2]);
        res  = '0;
        for (int k = 0; k < 4; k++)
            if (k < 4 - o) res[32*k +: 32] = words[line*4 + o + k];
        return res;
    endfunction

    function automatic logic [1:0] exp_count(input logic [31:0] a);
        return 2'(3 - int'(a[3:2]));
    endfunction

    function automatic logic exp_fault(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (off >= 32'(16 * NLINES));
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic flush();
        req    = 1'b0;
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        step();
        sample();
        checks++; if (bus0.inst_valid !== 1'b0 || sram_en0 !== 1'b0) begin
            errors++; $display("FAIL rst_during_dut0: valid=%b sram_en=%b expected 0/0", bus0.inst_valid, sram_en0); end
        checks++; if (bus3.inst_valid !== 1'b0 || sram_en3 !== 1'b0) begin
            errors++; $display("FAIL rst_during_dut3: valid=%b sram_en=%b expected 0/0", bus3.inst_valid, sram_en3); end
        step();
        reset = 1'b0;
        sample();
        checks++; if (bus0.inst_addr_ok !== 1'b1 || bus3.inst_addr_ok !== 1'b1) begin
            errors++; $display("FAIL rst_addr_ok: got %b/%b expected 1/1", bus0.inst_addr_ok, bus3.inst_addr_ok); end
        checks++; if (bus0.inst_rdata !== 128'd0 || bus0.inst_count !== 2'd0 || bus0.inst_ex !== 1'b0 ||
                      bus0.inst_exccode !== 6'd0 || bus0.inst_uncache !== 1'b0 || bus0.inst_valid !== 1'b0) begin
            errors++; $display("FAIL rst_outputs: rdata=%h count=%0d ex=%b code=%h unc=%b valid=%b expected all 0",
                               bus0.inst_rdata, bus0.inst_count, bus0.inst_ex, bus0.inst_exccode,
                               bus0.inst_uncache, bus0.inst_valid); end
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic_read();
        addr = BASE;
        req  = 1'b1;
        sample();
        checks++; if (bus0.inst_addr_ok !== 1'b1) begin
            errors++; $display("FAIL basic_addr_ok: got %b expected 1", bus0.inst_addr_ok); end
        step();
        req = 1'b0;
        sample();
        checks++; if (sram_en0 !== 1'b1 || sram_addr0 !== '0 || bus0.inst_valid !== 1'b0) begin
            errors++; $display("FAIL basic_read: sram_en=%b sram_addr=%0d valid=%b expected 1/0/0",
                               sram_en0, sram_addr0, bus0.inst_valid); end
        step();
        sample();
        checks++; if (bus0.inst_valid !== 1'b1 || bus0.inst_rdata !== line_of('0) ||
                      bus0.inst_count !== 2'd3 || bus0.inst_ex !== 1'b0) begin
            errors++; $display("FAIL basic_resp: valid=%b rdata=%h count=%0d ex=%b expected 1/%h/3/0",
                               bus0.inst_valid, bus0.inst_rdata, bus0.inst_count, bus0.inst_ex, line_of('0)); end
        step();
        sample();
        checks++; if (bus0.inst_valid !== 1'b0) begin
            errors++; $display("FAIL basic_single_pulse: valid=%b expected 0", bus0.inst_valid); end
        step();

        // Line 1, word offset 2: only the upper two words of the line return.
        addr = BASE + 32'h18;
        req  = 1'b1;
        sample();
        step();
        req = 1'b0;
        sample();
        checks++; if (sram_en0 !== 1'b1 || sram_addr0 !== AW'(1)) begin
            errors++; $display("FAIL offset_read: sram_en=%b sram_addr=%0d expected 1/1", sram_en0, sram_addr0); end
        step();
        sample();
        checks++; if (bus0.inst_valid !== 1'b1 || bus0.inst_rdata !== {64'd0, words[7], words[6]} ||
                      bus0.inst_count !== 2'd1) begin
            errors++; $display("FAIL offset_resp: valid=%b rdata=%h count=%0d expected 1/%h/1",
                               bus0.inst_valid, bus0.inst_rdata, bus0.inst_count, {64'd0, words[7], words[6]}); end
        step();
        flush();
    endtask

    // ------------------------------------------------------------------
    task automatic test_exceptions();
        logic [31:0] bad [3];
        bad[0] = BASE + 32'h2;
        bad[1] = BASE + 32'h4000;
        bad[2] = BASE - 32'h4;
        for (int i = 0; i < 3; i++) begin
            addr = bad[i];
            req  = 1'b1;
            sample();
            step();
            req = 1'b0;
            sample();
            checks++; if (sram_en0 !== 1'b0 || sram_en3 !== 1'b0 || bus0.inst_valid !== 1'b0) begin
                errors++; $display("FAIL ex_t1_%0d: sram_en=%b/%b valid=%b expected 0/0/0",
                                   i, sram_en0, sram_en3, bus0.inst_valid); end
            step();
            sample();
            checks++; if (bus0.inst_valid !== 1'b1 || bus0.inst_ex !== 1'b1 || bus0.inst_exccode !== 6'h08 ||
                          bus0.inst_count !== 2'd0 || bus0.inst_rdata !== 128'd0 || sram_en0 !== 1'b0) begin
                errors++; $display("FAIL ex_resp_dut0_%0d: valid=%b ex=%b code=%h count=%0d rdata=%h sram_en=%b expected 1/1/08/0/0/0",
                                   i, bus0.inst_valid, bus0.inst_ex, bus0.inst_exccode, bus0.inst_count,
                                   bus0.inst_rdata, sram_en0); end
            checks++; if (bus3.inst_valid !== 1'b1 || bus3.inst_ex !== 1'b1 || sram_en3 !== 1'b0) begin
                errors++; $display("FAIL ex_resp_dut3_%0d: valid=%b ex=%b sram_en=%b expected 1/1/0",
                                   i, bus3.inst_valid, bus3.inst_ex, sram_en3); end
            step();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [31:0] list [3];
        int          exp_cyc [3];
        int          idx, nresp;
        list[0] = BASE + 32'h10;  exp_cyc[0] = 5;
        list[1] = BASE + 32'h24;  exp_cyc[1] = 11;
        list[2] = BASE + 32'h3c;  exp_cyc[2] = 17;
        idx   = 0;
        nresp = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            req  = (idx < 3);
            addr = list[idx % 3];
            sample();
            if (cyc == 2 || cyc == 5) begin
                checks++; if (bus3.inst_addr_ok !== 1'b0) begin
                    errors++; $display("FAIL b2b_full_cyc%0d: addr_ok=%b expected 0", cyc, bus3.inst_addr_ok); end
            end
            if (cyc == 6) begin
                checks++; if (bus3.inst_addr_ok !== 1'b1) begin
                    errors++; $display("FAIL b2b_reopen: addr_ok=%b expected 1", bus3.inst_addr_ok); end
            end
            if (bus3.inst_valid === 1'b1) begin
                if (nresp < 3) begin
                    checks++; if (cyc !== exp_cyc[nresp] || bus3.inst_rdata !== exp_rdata(list[nresp]) ||
                                  bus3.inst_count !== exp_count(list[nresp])) begin
                        errors++; $display("FAIL b2b_resp%0d: cyc=%0d rdata=%h count=%0d expected cyc=%0d rdata=%h count=%0d",
                                           nresp, cyc, bus3.inst_rdata, bus3.inst_count, exp_cyc[nresp],
                                           exp_rdata(list[nresp]), exp_count(list[nresp])); end
                end
                nresp++;
            end
            if (req && bus3.inst_addr_ok === 1'b1) idx++;
            step();
        end
        req = 1'b0;
        checks++; if (nresp != 3) begin
            errors++; $display("FAIL b2b_count: got %0d responses expected 3", nresp); end
        flush();
    endtask

    // ------------------------------------------------------------------
    task automatic test_cancel();
        logic [31:0] d_addr;
        int          hits, hit_at;
        d_addr = BASE + 32'h1234;
        addr = BASE + 32'h40;  req = 1'b1;  step();
        addr = BASE + 32'h54;  step();
        req = 1'b0;            step();
        step();
        // dut3 is in READ for the first request, with two entries pending.
        cancel = 1'b1;
        sample();
        checks++; if (bus3.inst_valid !== 1'b0 || sram_en3 !== 1'b0 || bus3.inst_addr_ok !== 1'b0) begin
            errors++; $display("FAIL cancel_cycle: valid=%b sram_en=%b addr_ok=%b expected 0/0/0",
                               bus3.inst_valid, sram_en3, bus3.inst_addr_ok); end
        step();
        cancel = 1'b0;
        addr   = d_addr;
        req    = 1'b1;
        sample();
        checks++; if (bus3.inst_valid !== 1'b0 || bus3.inst_addr_ok !== 1'b1) begin
            errors++; $display("FAIL cancel_after: valid=%b addr_ok=%b expected 0/1", bus3.inst_valid, bus3.inst_addr_ok); end
        step();
        req    = 1'b0;
        hits   = 0;
        hit_at = -1;
        for (int i = 1; i <= 10; i++) begin
            sample();
            if (bus3.inst_valid === 1'b1) begin
                hits++;
                hit_at = i;
                checks++; if (bus3.inst_rdata !== exp_rdata(d_addr) || bus3.inst_count !== exp_count(d_addr)) begin
                    errors++; $display("FAIL cancel_new_data: rdata=%h count=%0d expected %h/%0d",
                                       bus3.inst_rdata, bus3.inst_count, exp_rdata(d_addr), exp_count(d_addr)); end
            end
            step();
        end
        checks++; if (hits != 1 || hit_at != 5) begin
            errors++; $display("FAIL cancel_new_timing: %0d responses, last at +%0d expected 1 at +5", hits, hit_at); end
        flush();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        int hits;
        addr = BASE + 32'h80;
        req  = 1'b1;
        step();
        req = 1'b0;
        step();
        // dut3 is waiting on the request; reset discards it.
        reset = 1'b1;
        sample();
        checks++; if (bus3.inst_valid !== 1'b0 || sram_en3 !== 1'b0) begin
            errors++; $display("FAIL rstmid_during: valid=%b sram_en=%b expected 0/0", bus3.inst_valid, sram_en3); end
        step();
        reset = 1'b0;
        sample();
        checks++; if (bus3.inst_addr_ok !== 1'b1 || bus3.inst_rdata !== 128'd0 || bus3.inst_count !== 2'd0 ||
                      bus3.inst_ex !== 1'b0 || bus3.inst_exccode !== 6'd0 || sram_en3 !== 1'b0) begin
            errors++; $display("FAIL rstmid_after: addr_ok=%b rdata=%h count=%0d ex=%b code=%h sram_en=%b expected 1/0/0/0/0/0",
                               bus3.inst_addr_ok, bus3.inst_rdata, bus3.inst_count, bus3.inst_ex,
                               bus3.inst_exccode, sram_en3); end
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (bus3.inst_valid === 1'b1 || sram_en3 === 1'b1) hits++;
            step();
        end
        checks++; if (hits != 0) begin
            errors++; $display("FAIL rstmid_no_resp: %0d active cycles expected 0", hits); end
    endtask

    // ------------------------------------------------------------------
    // Randomized run. The model tracks, per responder, the accepted requests
    // and the cycles at which each one reads and responds:
    //   start  = acceptance cycle for a good request into an empty queue,
    //            else one cycle after acceptance or after the previous
    //            response, whichever is later
    //   read   = start + 1 + W, response = start + 2 + W (fault: start + 1)
    task automatic test_random();
        int          pn  [2];
        logic [31:0] pa  [2][2];
        logic        pe  [2][2];
        int          pr  [2][2];
        int          prd [2][2];
        logic        o_ok, o_valid, o_en, o_ex;
        logic [127:0] o_rdata, e_rdata;
        logic [1:0]  o_count, e_count;
        logic [5:0]  o_code, e_code;
        logic [AW-1:0] o_saddr, e_saddr;
        logic        e_ok, e_valid, e_en, e_ex, acc, was_empty, fx;
        int          w, last_r, d;

        pn[0] = 0;
        pn[1] = 0;
        for (int c = 0; c < 800; c++) begin
            req    = ($urandom_range(0, 99) < 60);
            cancel = ($urandom_range(0, 99) < 4);
            case ($urandom_range(0, 9))
                0:       addr = BASE + ($urandom_range(0, NLINES-1) << 4) + $urandom_range(1, 3);
                1:       addr = BASE + 32'h4000 + ($urandom_range(0, 255) << 2);
                2:       addr = BASE - ($urandom_range(1, 64) << 2);
                default: addr = BASE + ($urandom_range(0, NLINES-1) << 4) + ($urandom_range(0, 3) << 2);
            endcase
            sample();
            for (int k = 0; k < 2; k++) begin
                w       = (k == 0) ? 0 : 3;
                o_ok    = (k == 0) ? bus0.inst_addr_ok : bus3.inst_addr_ok;
                o_valid = (k == 0) ? bus0.inst_valid   : bus3.inst_valid;
                o_rdata = (k == 0) ? bus0.inst_rdata   : bus3.inst_rdata;
                o_count = (k == 0) ? bus0.inst_count   : bus3.inst_count;
                o_ex    = (k == 0) ? bus0.inst_ex      : bus3.inst_ex;
                o_code  = (k == 0) ? bus0.inst_exccode : bus3.inst_exccode;
                o_en    = (k == 0) ? sram_en0          : sram_en3;
                o_saddr = (k == 0) ? sram_addr0        : sram_addr3;

                e_ok    = !cancel && (pn[k] < 2);
                e_valid = !cancel && (pn[k] > 0) && (pr[k][0] == c);
                e_en    = !cancel && (pn[k] > 0) && (prd[k][0] == c);

                checks++; if (o_ok !== e_ok) begin
                    errors++; $display("FAIL rnd_addr_ok dut%0d cyc %0d: got %b expected %b", k, c, o_ok, e_ok); end
                checks++; if (o_valid !== e_valid) begin
                    errors++; $display("FAIL rnd_valid dut%0d cyc %0d: got %b expected %b", k, c, o_valid, e_valid); end
                checks++; if (o_en !== e_en) begin
                    errors++; $display("FAIL rnd_sram_en dut%0d cyc %0d: got %b expected %b", k, c, o_en, e_en); end
                if (e_en) begin
                    e_saddr = AW'((pa[k][0] - BASE) >> 4);
                    checks++; if (o_saddr !== e_saddr) begin
                        errors++; $display("FAIL rnd_sram_addr dut%0d cyc %0d: got %0d expected %0d", k, c, o_saddr, e_saddr); end
                end
                e_rdata = '0;
                e_count = 2'd0;
                e_ex    = 1'b0;
                e_code  = 6'd0;
                if (e_valid) begin
                    if (pe[k][0]) begin
                        e_ex   = 1'b1;
                        e_code = 6'h08;
                    end else begin
                        e_rdata = exp_rdata(pa[k][0]);
                        e_count = exp_count(pa[k][0]);
                    end
                end
                checks++; if (o_rdata !== e_rdata || o_count !== e_count || o_ex !== e_ex || o_code !== e_code) begin
                    errors++; $display("FAIL rnd_data dut%0d cyc %0d: got %h/%0d/%b/%h expected %h/%0d/%b/%h",
                                       k, c, o_rdata, o_count, o_ex, o_code, e_rdata, e_count, e_ex, e_code); end

                // Advance the model past this clock edge.
                if (cancel) begin
                    pn[k] = 0;
                end else begin
                    acc       = req && e_ok;
                    was_empty = (pn[k] == 0);
                    last_r    = was_empty ? 0 : pr[k][pn[k]-1];
                    if (e_valid) begin
                        pa[k][0]  = pa[k][1];
                        pe[k][0]  = pe[k][1];
                        pr[k][0]  = pr[k][1];
                        prd[k][0] = prd[k][1];
                        pn[k]     = pn[k] - 1;
                    end
                    if (acc) begin
                        fx = exp_fault(addr);
                        d  = (!fx && was_empty) ? c : (was_empty ? c + 1 : last_r + 1);
                        pa[k][pn[k]]  = addr;
                        pe[k][pn[k]]  = fx;
                        prd[k][pn[k]] = fx ? -1 : d + 1 + w;
                        pr[k][pn[k]]  = fx ? d + 1 : d + 2 + w;
                        pn[k]         = pn[k] + 1;
                    end
                end
            end
            step();
        end
        req    = 1'b0;
        cancel = 1'b0;
    endtask

    // ------------------------------------------------------------------
    initial begin
        reset  = 1'b1;
        req    = 1'b0;
        cancel = 1'b0;
        addr   = '0;
        for (int i = 0; i < NLINES*4; i++) words[i] = $urandom;

        test_reset();
        test_basic_read();
        test_exceptions();
        test_back_to_back();
        test_cancel();
        test_reset_mid();
        flush();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
